// File: rtl/key_pkg.sv
// Shared key indices, key count and per-key debounce FSM state type.
package key_pkg;

  localparam int unsigned NUM_KEYS  = 6;
  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;
  localparam int unsigned KEY_ENTER = 4;
  localparam int unsigned KEY_ESC   = 5;

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} key_state_e;

  // Counter width able to hold the largest of the three cycle counts minus one.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, sample register, debounce FSM with registered outputs.
// Optional auto-repeat is built only when KEY_AUTO_REPEAT_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_RATE     = 100000
`ifdef KEY_AUTO_REPEAT_EN
  ,
  parameter bit          REPEAT_EN       = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          s;
  key_state_e    state;
  logic [CW-1:0] cnt;

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
  logic [CW-1:0] rep_cnt;
  logic          rep_fast;
  logic [CW-1:0] rep_last;
  assign rep_last = rep_fast ? RATE_LAST : DELAY_LAST;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      s    <= 1'b0;
    end else begin
      sync <= {sync[0], key_n};
      s    <= ~sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      rel      <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rep_cnt  <= '0;
      rep_fast <= 1'b0;
`endif
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            state <= DEB_PRESS;
            cnt   <= ONE;
          end
        end
        DEB_PRESS: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= DEB_LAST) begin
            state    <= HELD;
            cnt      <= '0;
            level    <= 1'b1;
            press    <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            rep_cnt  <= '0;
            rep_fast <= 1'b0;
`endif
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HELD: begin
          if (!s) begin
            state   <= DEB_RELEASE;
            cnt     <= ONE;
`ifdef KEY_AUTO_REPEAT_EN
            rep_cnt <= '0;
          end else if (REPEAT_EN) begin
            if (rep_cnt >= rep_last) begin
              press    <= 1'b1;
              rep_cnt  <= '0;
              rep_fast <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + ONE;
            end
`endif
          end
        end
        DEB_RELEASE: begin
          if (s) begin
            // Bounce back to held: repeat resumes at the fast rate from zero.
            state    <= HELD;
            cnt      <= '0;
`ifdef KEY_AUTO_REPEAT_EN
            rep_cnt  <= '0;
            rep_fast <= 1'b1;
`endif
          end else if (cnt >= DEB_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            level    <= 1'b0;
            rel      <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            rep_fast <= 1'b0;
`endif
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Six-button front end: one key_debounce per key. Auto-repeat on REPEAT_MASK keys
// is compiled in only when KEY_AUTO_REPEAT_EN is defined.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_RATE     = 100000
`ifdef KEY_AUTO_REPEAT_EN
  ,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK = 6'b000011
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n_i,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
`ifdef KEY_AUTO_REPEAT_EN
      ,
      .REPEAT_EN      (REPEAT_MASK[k])
`endif
    ) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_n_i[k]),
      .level (key_level[k]),
      .press (key_press[k]),
      .rel   (key_release[k])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed sequences, a vector table and
// randomized stimulus against a sample-window reference model.
module tb_key_conditioner;
  import key_pkg::*;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;
  localparam int unsigned HL = D + 3;  // history: 3 pipeline stages plus debounce window

  logic                clk;
  logic                rst_n;
  logic [NUM_KEYS-1:0] key_n_i;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n_i    (key_n_i),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  // Reference model: raw pad history; a key flips when its last D synchronised
  // samples (raw delayed by three edges) all disagree with its accepted level.
  logic [NUM_KEYS-1:0] q[$];
  logic [NUM_KEYS-1:0] m_lvl, m_press, m_rel;
  logic [NUM_KEYS-1:0] rmask;
  int                  anchor[NUM_KEYS];
  int                  ival[NUM_KEYS];
  bit                  was_rel[NUM_KEYS];

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < HL; i++) q.push_back(6'h3F);
    m_lvl   = '0;
    m_press = '0;
    m_rel   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      anchor[k]  = 0;
      ival[k]    = RD;
      was_rel[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NUM_KEYS-1:0] raw);
    int n_on;
    int last;
    q.push_back(raw);
    if (q.size() > HL) void'(q.pop_front());
    last    = q.size() - 4;
    m_press = '0;
    m_rel   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      n_on = 0;
      for (int j = 0; j < D; j++) if (!q[last-j][k]) n_on++;
      if (!m_lvl[k] && n_on == D) begin
        m_lvl[k]   = 1'b1;
        m_press[k] = 1'b1;
        anchor[k]  = cyc;
        ival[k]    = RD;
        was_rel[k] = 1'b0;
      end else if (m_lvl[k] && n_on == 0) begin
        m_lvl[k] = 1'b0;
        m_rel[k] = 1'b1;
      end
`ifdef KEY_AUTO_REPEAT_EN
      else if (m_lvl[k] && rmask[k]) begin
        if (q[last][k]) begin
          was_rel[k] = 1'b1;
        end else if (was_rel[k]) begin
          anchor[k]  = cyc;
          ival[k]    = RR;
          was_rel[k] = 1'b0;
        end else if (cyc - anchor[k] == ival[k]) begin
          m_press[k] = 1'b1;
          anchor[k]  = cyc;
          ival[k]    = RR;
        end
      end
`endif
    end
  endtask

  // Drive at negedge, clock one edge, compare everything against the model.
  task automatic tick(input logic [NUM_KEYS-1:0] raw);
    key_n_i = raw;
    @(posedge clk);
    cyc++;
    model_step(raw);
    @(negedge clk);
    check("model", {key_level, key_press, key_release}, {m_lvl, m_press, m_rel});
  endtask

  typedef struct {
    logic [NUM_KEYS-1:0] raw;
    int                  len;
    logic [NUM_KEYS-1:0] lvl;
    int                  np;
    int                  nr;
  } vec_t;

  vec_t                tbl[12];
  logic [NUM_KEYS-1:0] raw;
  int                  np, nr;
  int unsigned         div;

  initial begin
    rmask   = 6'b000011;
    rst_n   = 1'b0;
    key_n_i = 6'h3F;
    model_reset();

    // Reset state and quiet idle
    repeat (3) @(negedge clk);
    check("reset_out", 18'({key_level, key_press, key_release}), 18'(0));
    rst_n = 1'b1;
    for (int j = 0; j < 50; j++) begin
      tick(6'h3F);
      check("idle_quiet", 18'(key_press | key_release | key_level), 18'(0));
    end

    // Clean press and release of key 0
    for (int j = 0; j < 10; j++) begin
      tick(6'h3E);
      check("clean_press", 18'(key_press[0]), 18'(j == 6));
      check("clean_level", 18'(key_level[0]), 18'(j >= 6));
    end
    for (int j = 0; j < 10; j++) begin
      tick(6'h3F);
      check("clean_release", 18'(key_release[0]), 18'(j == 6));
    end

    // Bounce on key 4: 3 low, 1 high, 2 low, then high
    for (int j = 0; j < 15; j++) begin
      case (j)
        0, 1, 2, 4, 5: tick(6'h2F);
        default:       tick(6'h3F);
      endcase
      check("bounce_quiet", 18'({key_press[4], key_level[4]}), 18'(0));
    end
    for (int j = 0; j < 10; j++) begin
      tick(6'h2F);
      check("bounce_press", 18'(key_press[4]), 18'(j == 6));
    end
    for (int j = 0; j < 10; j++) tick(6'h3F);

    // Simultaneous keys 2 and 3
    for (int j = 0; j < 10; j++) begin
      tick(6'h33);
      check("simul_press", 18'(key_press), 18'((j == 6) ? 6'h0C : 6'h00));
    end
    for (int j = 0; j < 10; j++) begin
      tick(6'h3F);
      check("simul_release", 18'(key_release), 18'((j == 6) ? 6'h0C : 6'h00));
    end

    // Vector table, keys 2..5 only
    tbl[0]  = '{6'h3F, 10, 6'h00, 0, 0};
    tbl[1]  = '{6'h3B, 3,  6'h00, 0, 0};
    tbl[2]  = '{6'h3F, 2,  6'h00, 0, 0};
    tbl[3]  = '{6'h3F, 10, 6'h00, 0, 0};
    tbl[4]  = '{6'h2F, 10, 6'h10, 1, 0};
    tbl[5]  = '{6'h3F, 10, 6'h00, 0, 1};
    tbl[6]  = '{6'h33, 10, 6'h0C, 2, 0};
    tbl[7]  = '{6'h13, 10, 6'h2C, 1, 0};
    tbl[8]  = '{6'h3F, 10, 6'h00, 0, 3};
    tbl[9]  = '{6'h1F, 5,  6'h00, 0, 0};
    tbl[10] = '{6'h1F, 5,  6'h20, 1, 0};
    tbl[11] = '{6'h3F, 10, 6'h00, 0, 1};
    for (int i = 0; i < 12; i++) begin
      np = 0;
      nr = 0;
      for (int j = 0; j < tbl[i].len; j++) begin
        tick(tbl[i].raw);
        np += $countones(key_press);
        nr += $countones(key_release);
      end
      check($sformatf("tbl%0d_level", i), 18'(key_level), 18'(tbl[i].lvl));
      check($sformatf("tbl%0d_npress", i), 18'(np), 18'(tbl[i].np));
      check($sformatf("tbl%0d_nrel", i), 18'(nr), 18'(tbl[i].nr));
    end

    // Reset while key 1 is held
    for (int j = 0; j < 10; j++) tick(6'h3D);
    check("hold_before_rst", 18'(key_level[1]), 18'(1));
    rst_n = 1'b0;
    #1;
    check("rst_clear", 18'({key_level, key_press, key_release}), 18'(0));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick(6'h3D);
      check("rst_repress", 18'(key_press[1]), 18'(j == 6));
    end
    for (int j = 0; j < 10; j++) tick(6'h3F);

`ifdef KEY_AUTO_REPEAT_EN
    // Auto-repeat on key 0, none on key 5
    for (int j = 0; j < 30; j++) begin
      tick(6'h3E);
      check("repeat_k0", 18'(key_press[0]),
            18'(j == 6 || j == 16 || j == 19 || j == 22 || j == 25 || j == 28));
    end
    for (int j = 0; j < 10; j++) tick(6'h3F);
    for (int j = 0; j < 30; j++) begin
      tick(6'h1F);
      check("norepeat_k5", 18'(key_press[5]), 18'(j == 6));
    end
    for (int j = 0; j < 10; j++) tick(6'h3F);
`endif

    // Randomized toggling: bouncy first, then long holds
    raw = 6'h3F;
    for (int i = 0; i < 3000; i++) begin
      div = (i < 1500) ? 6 : 40;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if ($urandom_range(div - 1) == 0) raw[k] = ~raw[k];
      end
      tick(raw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
